vc_pop_ctrl: RTL and testbench

Drain controller for the virtual-channel FIFOs of the PCIe transmission layer. It pops words from the VC0 and VC1 FIFOs under strict VC0 priority and routes each word, by its destination bit, to the D0 or D1 output FIFO. It honours output back-pressure through the destination almost-full flags. It is the read-side master of the VC FIFOs and the write-side master of the destination FIFOs.

---
 rtl/vc_pkg.sv | 19 +
 rtl/vc_prio_arbiter.sv | 31 +++
 rtl/vc_pop_ctrl.sv | 119 +++++++++++
 tb/tb_vc_pop_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_pkg.sv
// Shared types for the VC drain controller.
// State encoding, destination bit and source select.
package vc_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  typedef enum logic {
    SRC_VC0 = 1'b0,
    SRC_VC1 = 1'b1
  } src_t;

  localparam int DATA_WIDTH = 6;
  localparam int DEST_BIT   = DATA_WIDTH - 1;

endpackage

// File: rtl/vc_prio_arbiter.sv
// Strict-priority picker between the two VC FIFOs.
// VC0 always wins; VC1 only pops while VC0 is empty.
module vc_prio_arbiter
  import vc_pkg::*;
(
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output src_t src
);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    src  = SRC_VC0;
    unique case (1'b1)
      en & req0: begin
        gnt0 = 1'b1;
        src  = SRC_VC0;
      end
      en & ~req0 & req1: begin
        gnt1 = 1'b1;
        src  = SRC_VC1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vc_pop_ctrl.sv
// Drains VC0/VC1 FIFOs and routes each word by its
// destination bit into the D0 or D1 output FIFO.
module vc_pop_ctrl
  import vc_pkg::*;
#(
  parameter int data_width = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  vc0_empty,
  input  logic                  vc1_empty,
  input  logic [data_width-1:0] vc0_data,
  input  logic [data_width-1:0] vc1_data,
  input  logic                  d0_almost_full,
  input  logic                  d1_almost_full,
  input  logic                  d0_full,
  input  logic                  d1_full,
  output logic                  vc0_rd_enable,
  output logic                  vc1_rd_enable,
  output logic                  d0_wr_enable,
  output logic                  d1_wr_enable,
  output logic [data_width-1:0] d0_data_out,
  output logic [data_width-1:0] d1_data_out,
  output logic                  idle,
  output logic                  error_out
);

  localparam int dest_bit = data_width - 1;

  state_t                  state;
  state_t                  state_nxt;
  logic                    pop_ok;
  logic                    pend_valid;
  src_t                    pend_src;
  src_t                    pop_src;
  logic [data_width-1:0]   word;
  logic                    to_d1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_RESET;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!init) begin
      state_nxt = ST_RESET;
    end else begin
      unique case (state)
        ST_RESET:  state_nxt = ST_IDLE;
        ST_IDLE: begin
          if (!(vc0_empty && vc1_empty))
            state_nxt = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (vc0_empty && vc1_empty &&
              !pend_valid &&
              !d0_wr_enable && !d1_wr_enable)
            state_nxt = ST_IDLE;
        end
        default:   state_nxt = ST_RESET;
      endcase
    end
  end

  // Destination unknown before the read, so both flags gate the pop.
  always_comb begin
    pop_ok = init && (state == ST_ACTIVE) &&
             !d0_almost_full && !d1_almost_full;
  end

  vc_prio_arbiter u_arb (
    .en   (pop_ok),
    .req0 (~vc0_empty),
    .req1 (~vc1_empty),
    .gnt0 (vc0_rd_enable),
    .gnt1 (vc1_rd_enable),
    .src  (pop_src)
  );

  assign word  = (pend_src == SRC_VC1) ? vc1_data : vc0_data;
  assign to_d1 = word[dest_bit];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_valid   <= 1'b0;
      pend_src     <= SRC_VC0;
      d0_wr_enable <= 1'b0;
      d1_wr_enable <= 1'b0;
      d0_data_out  <= '0;
      d1_data_out  <= '0;
      idle         <= 1'b0;
    end else begin
      idle <= (state_nxt == ST_IDLE);
      if (!init) begin
        pend_valid   <= 1'b0;
        d0_wr_enable <= 1'b0;
        d1_wr_enable <= 1'b0;
      end else begin
        pend_valid   <= vc0_rd_enable | vc1_rd_enable;
        pend_src     <= pop_src;
        d0_wr_enable <= pend_valid & ~to_d1;
        d1_wr_enable <= pend_valid & to_d1;
        if (pend_valid && !to_d1) d0_data_out <= word;
        if (pend_valid && to_d1)  d1_data_out <= word;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      error_out <= 1'b0;
    else if ((d0_wr_enable && d0_full) ||
             (d1_wr_enable && d1_full))
      error_out <= 1'b1;
  end

endmodule

// File: tb/tb_vc_pop_ctrl.sv
// Directed bench for vc_pop_ctrl with behavioural
// VC FIFO models and a write/pop monitor.
module tb_vc_pop_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init = 1'b0;
  logic       vc0_empty, vc1_empty;
  logic [5:0] vc0_data = '0;
  logic [5:0] vc1_data = '0;
  logic       d0_almost_full = 1'b0;
  logic       d1_almost_full = 1'b0;
  logic       d0_full = 1'b0;
  logic       d1_full = 1'b0;
  logic       vc0_rd_enable, vc1_rd_enable;
  logic       d0_wr_enable, d1_wr_enable;
  logic [5:0] d0_data_out, d1_data_out;
  logic       idle, error_out;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  vc_pop_ctrl #(.data_width(6)) dut (
    .clk            (clk),
    .reset          (reset),
    .init           (init),
    .vc0_empty      (vc0_empty),
    .vc1_empty      (vc1_empty),
    .vc0_data       (vc0_data),
    .vc1_data       (vc1_data),
    .d0_almost_full (d0_almost_full),
    .d1_almost_full (d1_almost_full),
    .d0_full        (d0_full),
    .d1_full        (d1_full),
    .vc0_rd_enable  (vc0_rd_enable),
    .vc1_rd_enable  (vc1_rd_enable),
    .d0_wr_enable   (d0_wr_enable),
    .d1_wr_enable   (d1_wr_enable),
    .d0_data_out    (d0_data_out),
    .d1_data_out    (d1_data_out),
    .idle           (idle),
    .error_out      (error_out)
  );

  // VC FIFO models: tasks own the write pointers, the model owns reads.
  logic [5:0] m0 [64];
  logic [5:0] m1 [64];
  int wp0 = 0, wp1 = 0, rp0 = 0, rp1 = 0;

  assign vc0_empty = (wp0 == rp0);
  assign vc1_empty = (wp1 == rp1);

  always @(posedge clk) begin
    if (vc0_rd_enable) begin
      vc0_data <= m0[rp0 % 64];
      rp0 <= rp0 + 1;
    end
    if (vc1_rd_enable) begin
      vc1_data <= m1[rp1 % 64];
      rp1 <= rp1 + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         np = 0, n0 = 0, n1 = 0, overlap = 0;
  int         pop_cyc [256];
  logic       pop_src [256];
  int         d0_cyc  [256];
  int         d1_cyc  [256];
  logic [5:0] d0_log  [256];
  logic [5:0] d1_log  [256];

  always @(negedge clk) begin
    if (vc0_rd_enable && vc1_rd_enable) overlap = overlap + 1;
    if (vc0_rd_enable || vc1_rd_enable) begin
      pop_cyc[np] = cyc;
      pop_src[np] = vc1_rd_enable;
      np = np + 1;
    end
    if (d0_wr_enable) begin
      d0_log[n0] = d0_data_out;
      d0_cyc[n0] = cyc;
      n0 = n0 + 1;
    end
    if (d1_wr_enable) begin
      d1_log[n1] = d1_data_out;
      d1_cyc[n1] = cyc;
      n1 = n1 + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push0(input logic [5:0] w);
    m0[wp0 % 64] = w;
    wp0 = wp0 + 1;
  endtask

  task automatic push1(input logic [5:0] w);
    m1[wp1 % 64] = w;
    wp1 = wp1 + 1;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    repeat (2) step();
    while (!idle && k < 60) begin
      step();
      k++;
    end
    checks++;
    if (idle !== 1'b1) begin
      fails++;
      $display("FAIL %s idle timeout: got %b want 1", name, idle);
    end
  endtask

  task automatic wait_pop(input string name);
    int k;
    k = 0;
    while (!vc0_rd_enable && k < 20) begin
      step();
      k++;
    end
    checks++;
    if (vc0_rd_enable !== 1'b1) begin
      fails++;
      $display("FAIL %s pop timeout: got %b want 1", name, vc0_rd_enable);
    end
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    #1;
    checks++;
    if ({vc0_rd_enable, vc1_rd_enable, d0_wr_enable, d1_wr_enable} !== 4'b0) begin
      fails++;
      $display("FAIL reset_strobes got %b want 0000",
               {vc0_rd_enable, vc1_rd_enable, d0_wr_enable, d1_wr_enable});
    end
    checks++;
    if ({d0_data_out, d1_data_out} !== 12'h000) begin
      fails++;
      $display("FAIL reset_data got %h want 000", {d0_data_out, d1_data_out});
    end
    checks++;
    if ({idle, error_out} !== 2'b00) begin
      fails++;
      $display("FAIL reset_flags got %b want 00", {idle, error_out});
    end
    step();
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if (idle !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold_idle got %b want 0", idle);
    end
    init = 1'b1;
    step();
    checks++;
    if (idle !== 1'b1) begin
      fails++;
      $display("FAIL init_to_idle got %b want 1", idle);
    end
  endtask

  task automatic test_routing();
    int bp, b0, b1;
    bp = np; b0 = n0; b1 = n1;
    push0(6'h05); push0(6'h21); push0(6'h0A);
    wait_idle("routing");
    checks++;
    if (np - bp !== 3) begin
      fails++;
      $display("FAIL routing_pops got %0d want 3", np - bp);
    end
    checks++;
    if (n0 - b0 !== 2 || d0_log[b0] !== 6'h05 || d0_log[b0+1] !== 6'h0A) begin
      fails++;
      $display("FAIL routing_d0 got n=%0d %h %h want 2 05 0a",
               n0 - b0, d0_log[b0], d0_log[b0+1]);
    end
    checks++;
    if (n1 - b1 !== 1 || d1_log[b1] !== 6'h21) begin
      fails++;
      $display("FAIL routing_d1 got n=%0d %h want 1 21", n1 - b1, d1_log[b1]);
    end
    checks++;
    if (pop_cyc[bp+1] - pop_cyc[bp] !== 1 || pop_cyc[bp+2] - pop_cyc[bp] !== 2) begin
      fails++;
      $display("FAIL routing_back_to_back got %0d %0d want 1 2",
               pop_cyc[bp+1] - pop_cyc[bp], pop_cyc[bp+2] - pop_cyc[bp]);
    end
    checks++;
    if (d0_cyc[b0] - pop_cyc[bp] !== 2 || d1_cyc[b1] - pop_cyc[bp+1] !== 2 ||
        d0_cyc[b0+1] - pop_cyc[bp+2] !== 2) begin
      fails++;
      $display("FAIL routing_latency got %0d %0d %0d want 2 2 2",
               d0_cyc[b0] - pop_cyc[bp], d1_cyc[b1] - pop_cyc[bp+1],
               d0_cyc[b0+1] - pop_cyc[bp+2]);
    end
  endtask

  task automatic test_priority();
    int bp, b0, b1;
    bp = np; b0 = n0; b1 = n1;
    push0(6'h01); push0(6'h22); push1(6'h3F);
    wait_idle("priority");
    checks++;
    if (np - bp !== 3 || pop_src[bp] !== 1'b0 || pop_src[bp+1] !== 1'b0 ||
        pop_src[bp+2] !== 1'b1) begin
      fails++;
      $display("FAIL priority_order got n=%0d src=%b%b%b want 3 001", np - bp,
               pop_src[bp], pop_src[bp+1], pop_src[bp+2]);
    end
    checks++;
    if (overlap !== 0) begin
      fails++;
      $display("FAIL priority_overlap got %0d want 0", overlap);
    end
    checks++;
    if (n1 - b1 !== 2 || d1_log[b1] !== 6'h22 || d1_log[b1+1] !== 6'h3F ||
        n0 - b0 !== 1 || d0_log[b0] !== 6'h01) begin
      fails++;
      $display("FAIL priority_data got d1 n=%0d %h %h d0 n=%0d %h want 2 22 3f 1 01",
               n1 - b1, d1_log[b1], d1_log[b1+1], n0 - b0, d0_log[b0]);
    end
  endtask

  task automatic test_backpressure();
    int bp, b1;
    bp = np; b1 = n1;
    for (int i = 0; i < 6; i++) push0(6'h20 + 6'(i));
    step();
    wait_pop("bp");
    step();
    step();
    d1_almost_full = 1'b1;
    #1;
    checks++;
    if (vc0_rd_enable !== 1'b0) begin
      fails++;
      $display("FAIL bp_stop got %b want 0", vc0_rd_enable);
    end
    repeat (4) step();
    checks++;
    if (np - bp !== 2 || n1 - b1 !== 2) begin
      fails++;
      $display("FAIL bp_inflight got pops=%0d writes=%0d want 2 2", np - bp, n1 - b1);
    end
    d1_almost_full = 1'b0;
    #1;
    checks++;
    if (vc0_rd_enable !== 1'b1) begin
      fails++;
      $display("FAIL bp_resume got %b want 1", vc0_rd_enable);
    end
    wait_idle("bp");
    checks++;
    if (n1 - b1 !== 6 || d1_log[b1] !== 6'h20 || d1_log[b1+2] !== 6'h22 ||
        d1_log[b1+5] !== 6'h25) begin
      fails++;
      $display("FAIL bp_data got n=%0d %h %h %h want 6 20 22 25",
               n1 - b1, d1_log[b1], d1_log[b1+2], d1_log[b1+5]);
    end
  endtask

  task automatic test_error();
    checks++;
    if (error_out !== 1'b0) begin
      fails++;
      $display("FAIL error_pre got %b want 0", error_out);
    end
    d0_full = 1'b1;
    push0(6'h07);
    wait_idle("error");
    checks++;
    if (error_out !== 1'b1) begin
      fails++;
      $display("FAIL error_set got %b want 1", error_out);
    end
    d0_full = 1'b0;
    push0(6'h08);
    wait_idle("error2");
    checks++;
    if (error_out !== 1'b1) begin
      fails++;
      $display("FAIL error_sticky got %b want 1", error_out);
    end
  endtask

  task automatic test_async_reset();
    int b0, b1;
    push0(6'h15);
    step();
    wait_pop("arst");
    step();
    reset = 1'b0;
    init  = 1'b0;
    #1;
    checks++;
    if ({d0_wr_enable, d1_wr_enable, d0_data_out, d1_data_out} !== 14'h0) begin
      fails++;
      $display("FAIL arst_outputs got %b %b %h %h want 0 0 00 00",
               d0_wr_enable, d1_wr_enable, d0_data_out, d1_data_out);
    end
    checks++;
    if ({idle, error_out} !== 2'b00) begin
      fails++;
      $display("FAIL arst_flags got %b want 00", {idle, error_out});
    end
    b0 = n0; b1 = n1;
    step();
    reset = 1'b1;
    repeat (4) step();
    checks++;
    if (n0 !== b0 || n1 !== b1 || idle !== 1'b0 || vc0_rd_enable !== 1'b0) begin
      fails++;
      $display("FAIL arst_quiet got writes=%0d idle=%b rd=%b want 0 0 0",
               (n0 - b0) + (n1 - b1), idle, vc0_rd_enable);
    end
    init = 1'b1;
    step();
    checks++;
    if (idle !== 1'b1) begin
      fails++;
      $display("FAIL arst_reinit got %b want 1", idle);
    end
  endtask

  task automatic test_init_drop();
    int bp, b0;
    bp = np; b0 = n0;
    push0(6'h02); push0(6'h03); push0(6'h04); push0(6'h05);
    step();
    wait_pop("initdrop");
    step();
    init = 1'b0;
    #1;
    checks++;
    if (vc0_rd_enable !== 1'b0) begin
      fails++;
      $display("FAIL initdrop_nopop got %b want 0", vc0_rd_enable);
    end
    step();
    checks++;
    if ({d0_wr_enable, d1_wr_enable, idle} !== 3'b000) begin
      fails++;
      $display("FAIL initdrop_flush got %b want 000", {d0_wr_enable, d1_wr_enable, idle});
    end
    init = 1'b1;
    wait_idle("initdrop");
    checks++;
    if (np - bp !== 4 || n0 - b0 !== 3 || d0_log[b0] !== 6'h03 ||
        d0_log[b0+1] !== 6'h04 || d0_log[b0+2] !== 6'h05) begin
      fails++;
      $display("FAIL initdrop_data got pops=%0d n=%0d %h %h %h want 4 3 03 04 05",
               np - bp, n0 - b0, d0_log[b0], d0_log[b0+1], d0_log[b0+2]);
    end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_priority();
    test_backpressure();
    test_error();
    test_async_reset();
    test_init_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
